imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Sequences the two-program instruction ROM: owns the fetch PC and the ROM select.
//  Presents each fetched word to decode through a registered valid/ready stage.
//  Detects end of program and chains ROM0 -> ROM1. Applies branch/jump redirects.
//  Sits between the CPU control path and the instruction memory (combinational read on pc, sel).
// PARAMETERS
//  DEPTH0     336           words in ROM0 (sel=0)
//  DEPTH1     77            words in ROM1 (sel=1)
//  RESET_PC   32'h0         start PC for every program
//  HALT_WORD  32'h00000000  fetched word that marks end of program
//  AUTO_CHAIN 1             1: ROM0 end starts ROM1 automatically; 0: stop after any program
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   synchronous, active-low reset
//  start          in   1   pulse: begin a run (accepted in IDLE only)
//  start_sel      in   1   program for the run started by start
//  imem_pc        out  32  PC driven to instruction memory
//  imem_sel       out  1   ROM select driven to instruction memory
//  imem_instr     in   32  word returned combinationally by instruction memory
//  redirect_valid in   1   taken branch/jump from execute
//  redirect_pc    in   32  redirect target; bits [1:0] are forced to 0
//  if_valid       out  1   if_instr/if_pc/if_sel hold a fetched instruction
//  if_ready       in   1   decode accepts the word when if_valid && if_ready
//  if_instr       out  32  fetched instruction
//  if_pc          out  32  PC of if_instr
//  if_sel         out  1   ROM of if_instr
//  busy           out  1   high in every state except IDLE
//  done           out  1   one-cycle pulse at run completion
//  instr_count    out  16  instructions accepted in the current run; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; imem_pc=RESET_PC; imem_sel=0
//   - if_valid=0; if_instr=0; if_pc=0; if_sel=0
//   - busy=0; done=0; instr_count=0
//   - Reset asserted in any state aborts the run at that edge. No done pulse.
//  States and transitions:
//   IDLE:   start=1 -> imem_pc<=RESET_PC, imem_sel<=start_sel, instr_count<=0, go FETCH. Redirect ignored.
//   FETCH:  load slot = !if_valid || if_ready.
//           End condition: imem_instr==HALT_WORD, or imem_pc[10:2] >= depth of imem_sel.
//           - On load slot with no end condition: capture {imem_instr, imem_pc, imem_sel} into if_*,
//             set if_valid<=1, imem_pc<=imem_pc+4.
//           - On load slot with the end condition: nothing is captured; go DRAIN.
//           - No load slot: hold everything.
//   DRAIN:  wait until if_valid==0 (last word accepted).
//           Then if imem_sel==0 && AUTO_CHAIN: go SWITCH; else go DONE.
//   SWITCH: one cycle; imem_sel<=1, imem_pc<=RESET_PC, instr_count<=0; go FETCH.
//   DONE:   done=1 for exactly this cycle; go IDLE. start here is ignored.
//  Redirect (FETCH/DRAIN/SWITCH):
//   - Highest priority: if_valid<=0 (flush; a word with if_ready in the same cycle is still counted),
//     imem_pc<={redirect_pc[31:2],2'b00}, imem_sel unchanged, go FETCH.
//  Handshake: if_* stable while if_valid && !if_ready; if_valid never drops without acceptance except by redirect or reset.
//  Latency: word at imem_pc appears on if_* one clock after the load slot; throughput 1 word/cycle when if_ready=1.
//  instr_count: +1 on each if_valid && if_ready; saturating 16-bit.
// STRUCTURE
//  Package imem_pkg:
//   - constants IMEM_DEPTH0, IMEM_DEPTH1, IMEM_HALT_WORD
//   - fetch_state_t {IDLE, FETCH, DRAIN, SWITCH, DONE}
//  Sub-module if_stage_reg: valid/ready pipeline register for {instr, pc, sel} with flush input.
//  FSM, PC/sel registers, bound check and counter stay in imem_fetch_ctrl.
// TESTING
//  1. Basic run: start, start_sel=0, if_ready=1, ROM0 word[3]=0.
//     -> if_pc 0,4,8 on consecutive cycles; ROM1 run follows; done once; instr_count counts ROM1 only.
//  2. Backpressure: if_ready=0 for 5 cycles at if_pc=8 -> if_instr/if_pc held, imem_pc stays 12, no word lost.
//  3. Redirect: redirect_valid with redirect_pc=32'h23 while if_valid.
//     -> flush; next if_pc=32'h20; imem_sel unchanged.
//  4. Bound: ROM1 fully nonzero.
//     -> last if_pc=32'h130 (word 76); DRAIN; DONE; no SWITCH from ROM1.
//  5. Reset mid-run: rst_n=0 in FETCH at pc=0x40.
//     -> next cycle IDLE, if_valid=0, imem_pc=0, no done.
//     Then start_sel=1 runs ROM1 only.
//  6. Edge cases: start during DONE ignored; redirect in IDLE ignored; instr_count saturates at 16'hFFFF (forced-long run with redirect loop).

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package imem_pkg;

   localparam int unsigned IMEM_XLEN      = 32;
   localparam int unsigned IMEM_DEPTH0    = 336;
   localparam int unsigned IMEM_DEPTH1    = 77;
   localparam logic [31:0] IMEM_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] IMEM_HALT_WORD = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      SWITCH,
      DONE
   } fetch_state_t;

   // Instruction counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory read port plus the decode valid/ready stage.
// master = fetch controller, slave = memory/decode side.
interface imem_fetch_ctrl_if;
   import imem_pkg::*;

   logic [IMEM_XLEN-1:0] imem_pc;
   logic                 imem_sel;
   logic [IMEM_XLEN-1:0] imem_instr;

   logic                 if_valid;
   logic                 if_ready;
   logic [IMEM_XLEN-1:0] if_instr;
   logic [IMEM_XLEN-1:0] if_pc;
   logic                 if_sel;

   modport master (
      output imem_pc,
      output imem_sel,
      input  imem_instr,
      output if_valid,
      input  if_ready,
      output if_instr,
      output if_pc,
      output if_sel
   );

   modport slave (
      input  imem_pc,
      input  imem_sel,
      output imem_instr,
      input  if_valid,
      output if_ready,
      input  if_instr,
      input  if_pc,
      input  if_sel
   );

endinterface

// File: rtl/imem_fetch_ctrl_if_stage_reg.sv
// Valid/ready pipeline register holding one fetched {instr, pc, sel}.
// Flush drops the held word; payload is only rewritten on load so it stays
// stable while the consumer stalls.
module if_stage_reg
   import imem_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 load,
   input  logic                 ready,
   input  logic [IMEM_XLEN-1:0] load_instr,
   input  logic [IMEM_XLEN-1:0] load_pc,
   input  logic                 load_sel,
   output logic                 valid,
   output logic [IMEM_XLEN-1:0] instr,
   output logic [IMEM_XLEN-1:0] pc,
   output logic                 sel
);

   logic                 valid_reg;
   logic [IMEM_XLEN-1:0] instr_reg;
   logic [IMEM_XLEN-1:0] pc_reg;
   logic                 sel_reg;

   // Flush beats load; an accepted word with nothing new behind it empties the slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         instr_reg <= '0;
         pc_reg    <= '0;
         sel_reg   <= 1'b0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg <= 1'b1;
         instr_reg <= load_instr;
         pc_reg    <= load_pc;
         sel_reg   <= load_sel;
      end else if (ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign valid = valid_reg;
   assign instr = instr_reg;
   assign pc    = pc_reg;
   assign sel   = sel_reg;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer for the two-program ROM. Owns PC and ROM select,
// detects end of program (halt word or past the ROM depth), chains ROM0 into
// ROM1, applies execute redirects and counts words accepted by decode.
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH0     = IMEM_DEPTH0,
   parameter int unsigned DEPTH1     = IMEM_DEPTH1,
   parameter logic [31:0] RESET_PC   = IMEM_RESET_PC,
   parameter logic [31:0] HALT_WORD  = IMEM_HALT_WORD,
   parameter bit          AUTO_CHAIN = 1'b1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    start_sel,
   imem_fetch_ctrl_if.master       bus,
   input  logic                    redirect_valid,
   input  logic [31:0]             redirect_pc,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             instr_count
);

   fetch_state_t state_reg;
   logic [31:0]  pc_reg;
   logic         sel_reg;
   logic [15:0]  count_reg;
   logic         busy_reg;
   logic         done_reg;

   logic [8:0]   pc_word;
   logic [31:0]  cur_depth;
   logic         past_end;
   logic         halt_hit;
   logic         end_cond;
   logic         load_slot;
   logic         redirect_live;
   logic         capture;
   logic         accept;
   logic [31:0]  redirect_target;

   // Bound check uses the word index within the currently selected ROM.
   assign pc_word   = pc_reg[10:2];
   assign cur_depth = sel_reg ? 32'(DEPTH1) : 32'(DEPTH0);
   assign past_end  = ({23'd0, pc_word} >= cur_depth);
   assign halt_hit  = (bus.imem_instr == HALT_WORD);
   assign end_cond  = halt_hit || past_end;

   // The stage can take a new word when it is empty or its word leaves this cycle.
   assign load_slot = !bus.if_valid || bus.if_ready;
   assign accept    = bus.if_valid && bus.if_ready;

   // Redirects only matter while a run is in flight; IDLE and DONE ignore them.
   assign redirect_live   = redirect_valid &&
                            ((state_reg == FETCH) || (state_reg == DRAIN) || (state_reg == SWITCH));
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   assign capture = (state_reg == FETCH) && !redirect_live && load_slot && !end_cond;

   if_stage_reg u_if_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_live),
      .load       (capture),
      .ready      (bus.if_ready),
      .load_instr (bus.imem_instr),
      .load_pc    (pc_reg),
      .load_sel   (sel_reg),
      .valid      (bus.if_valid),
      .instr      (bus.if_instr),
      .pc         (bus.if_pc),
      .sel        (bus.if_sel)
   );

   // Run sequencing: state, PC/select, counter and registered busy/done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pc_reg    <= RESET_PC;
         sel_reg   <= 1'b0;
         count_reg <= 16'd0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;

         // A word leaving the stage is counted even if a redirect flushes behind it.
         if (accept) begin
            count_reg <= sat_inc16(count_reg);
         end

         case (state_reg)
            IDLE: begin
               if (start) begin
                  pc_reg    <= RESET_PC;
                  sel_reg   <= start_sel;
                  count_reg <= 16'd0;
                  busy_reg  <= 1'b1;
                  state_reg <= FETCH;
               end
            end

            FETCH: begin
               if (redirect_live) begin
                  pc_reg    <= redirect_target;
                  state_reg <= FETCH;
               end else if (load_slot) begin
                  if (end_cond) begin
                     state_reg <= DRAIN;
                  end else begin
                     pc_reg <= pc_reg + 32'd4;
                  end
               end
            end

            DRAIN: begin
               if (redirect_live) begin
                  pc_reg    <= redirect_target;
                  state_reg <= FETCH;
               end else if (!bus.if_valid) begin
                  if (!sel_reg && AUTO_CHAIN) begin
                     state_reg <= SWITCH;
                  end else begin
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
                  end
               end
            end

            SWITCH: begin
               if (redirect_live) begin
                  pc_reg    <= redirect_target;
                  state_reg <= FETCH;
               end else begin
                  sel_reg   <= 1'b1;
                  pc_reg    <= RESET_PC;
                  count_reg <= 16'd0;
                  state_reg <= FETCH;
               end
            end

            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.imem_pc  = pc_reg;
   assign bus.imem_sel = sel_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign instr_count  = count_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: cycle table for basic run, backpressure, redirect
// and IDLE/DONE corner cases, then hand sequences for bound, reset and saturation.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        start_sel;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
   logic        done;
   logic [15:0] instr_count;

   int errors = 0;
   int checks = 0;

   logic [31:0] rom0 [512];
   logic [31:0] rom1 [512];

   always #5 clk = ~clk;

   imem_fetch_ctrl_if bus ();

   // Instruction memory model: combinational read on {sel, pc}.
   always_comb begin
      bus.imem_instr = bus.imem_sel ? rom1[bus.imem_pc[10:2]] : rom0[bus.imem_pc[10:2]];
   end

   imem_fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .start_sel      (start_sel),
      .bus            (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .done           (done),
      .instr_count    (instr_count)
   );

   typedef struct {
      int          rst_n;
      int          start;
      int          ready;
      int          redir;
      logic [31:0] rpc;
      int          v;
      logic [31:0] ipc;
      int          isel;
      logic [31:0] mpc;
      int          msel;
      int          busy;
      int          done;
      int          cnt;
   } vec_t;

   localparam int NV = 34;
   vec_t vecs [NV];

   function automatic vec_t mk(int r, int s, int rdy, int rd, logic [31:0] rpc,
                               int v, logic [31:0] ipc, int isel, logic [31:0] mpc,
                               int msel, int b, int d, int c);
      vec_t x;
      x.rst_n = r;   x.start = s;   x.ready = rdy; x.redir = rd;  x.rpc = rpc;
      x.v = v;       x.ipc = ipc;   x.isel = isel; x.mpc = mpc;   x.msel = msel;
      x.busy = b;    x.done = d;    x.cnt = c;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rom_word(input int sel, input logic [31:0] pc);
      return (sel != 0) ? rom1[pc[10:2]] : rom0[pc[10:2]];
   endfunction

   // Starts a run and follows it until busy drops, logging what decode saw.
   task automatic run_to_done(input logic sel, output int accepted, output logic [31:0] last_pc,
                              output int dones, output int sel_flips, output int finished);
      accepted = 0; last_pc = '0; dones = 0; sel_flips = 0; finished = 0;
      @(negedge clk);
      start = 1'b1; start_sel = sel;
      @(posedge clk); #1;
      start = 1'b0; start_sel = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if (bus.if_valid && bus.if_ready) begin
            accepted++;
            last_pc = bus.if_pc;
         end
         if (done) dones++;
         if (bus.imem_sel != sel) sel_flips++;
         if (!busy) begin
            finished = 1;
            break;
         end
      end
   endtask

   initial begin
      int          acc;
      int          dn;
      int          flips;
      int          fin;
      int          reached;
      int          sat_hits;
      int          wraps;
      logic [31:0] lpc;

      rst_n = 1'b0; start = 1'b0; start_sel = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; bus.if_ready = 1'b0;
      for (int i = 0; i < 512; i++) begin
         rom0[i] = 32'hA000_0000 | 32'(i);
         rom1[i] = 32'hB000_0000 | 32'(i);
      end
      rom0[3] = 32'h0;   // ROM0 program: words 0..2
      rom1[2] = 32'h0;   // ROM1 program: words 0..1

      //             rst st rdy rd rpc      v  ipc    is mpc    ms b  d  cnt
      vecs[0]  = mk(0, 0, 0, 0, 0,        0, 0,     0, 0,     0, 0, 0, 0);
      vecs[1]  = mk(1, 1, 1, 0, 0,        0, 0,     0, 0,     0, 1, 0, 0);
      vecs[2]  = mk(1, 0, 1, 0, 0,        1, 0,     0, 4,     0, 1, 0, 0);
      vecs[3]  = mk(1, 0, 1, 0, 0,        1, 4,     0, 8,     0, 1, 0, 1);
      vecs[4]  = mk(1, 0, 1, 0, 0,        1, 8,     0, 12,    0, 1, 0, 2);
      vecs[5]  = mk(1, 0, 1, 0, 0,        0, 8,     0, 12,    0, 1, 0, 3);
      vecs[6]  = mk(1, 0, 1, 0, 0,        0, 8,     0, 12,    0, 1, 0, 3);
      vecs[7]  = mk(1, 0, 1, 0, 0,        0, 8,     0, 0,     1, 1, 0, 0);
      vecs[8]  = mk(1, 0, 1, 0, 0,        1, 0,     1, 4,     1, 1, 0, 0);
      vecs[9]  = mk(1, 0, 1, 0, 0,        1, 4,     1, 8,     1, 1, 0, 1);
      vecs[10] = mk(1, 0, 1, 0, 0,        0, 4,     1, 8,     1, 1, 0, 2);
      vecs[11] = mk(1, 0, 1, 0, 0,        0, 4,     1, 8,     1, 1, 1, 2);
      vecs[12] = mk(1, 1, 1, 0, 0,        0, 4,     1, 8,     1, 0, 0, 2);  // start in DONE
      vecs[13] = mk(1, 0, 1, 1, 32'h40,   0, 4,     1, 8,     1, 0, 0, 2);  // redirect in IDLE
      vecs[14] = mk(1, 0, 1, 0, 0,        0, 4,     1, 8,     1, 0, 0, 2);
      vecs[15] = mk(1, 1, 1, 0, 0,        0, 4,     1, 0,     0, 1, 0, 0);
      vecs[16] = mk(1, 0, 1, 0, 0,        1, 0,     0, 4,     0, 1, 0, 0);
      vecs[17] = mk(1, 0, 1, 0, 0,        1, 4,     0, 8,     0, 1, 0, 1);
      vecs[18] = mk(1, 0, 1, 0, 0,        1, 8,     0, 12,    0, 1, 0, 2);
      for (int i = 19; i <= 23; i++)                                        // backpressure
         vecs[i] = mk(1, 0, 0, 0, 0,      1, 8,     0, 12,    0, 1, 0, 2);
      vecs[24] = mk(1, 0, 1, 0, 0,        0, 8,     0, 12,    0, 1, 0, 3);
      vecs[25] = mk(1, 0, 1, 0, 0,        0, 8,     0, 12,    0, 1, 0, 3);
      vecs[26] = mk(1, 0, 1, 0, 0,        0, 8,     0, 0,     1, 1, 0, 0);
      vecs[27] = mk(1, 0, 1, 0, 0,        1, 0,     1, 4,     1, 1, 0, 0);
      vecs[28] = mk(1, 0, 0, 1, 32'h23,   0, 0,     1, 32'h20, 1, 1, 0, 0);
      vecs[29] = mk(1, 0, 1, 0, 0,        1, 32'h20, 1, 32'h24, 1, 1, 0, 0);
      vecs[30] = mk(1, 0, 1, 1, 32'h0A,   0, 32'h20, 1, 8,     1, 1, 0, 1);  // flush + count
      vecs[31] = mk(1, 0, 1, 0, 0,        0, 32'h20, 1, 8,     1, 1, 0, 1);
      vecs[32] = mk(1, 0, 1, 0, 0,        0, 32'h20, 1, 8,     1, 1, 1, 1);
      vecs[33] = mk(1, 0, 1, 0, 0,        0, 32'h20, 1, 8,     1, 0, 0, 1);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst_n          = (vecs[i].rst_n != 0);
         start          = (vecs[i].start != 0);
         start_sel      = 1'b0;
         bus.if_ready   = (vecs[i].ready != 0);
         redirect_valid = (vecs[i].redir != 0);
         redirect_pc    = vecs[i].rpc;
         @(posedge clk); #1;
         $display("vec %0d: valid=%0d if_pc=%h imem_pc=%h sel=%0d busy=%0d done=%0d cnt=%0d",
                  i, bus.if_valid, bus.if_pc, bus.imem_pc, bus.imem_sel, busy, done, instr_count);
         check($sformatf("v%0d if_valid", i),    32'(bus.if_valid), vecs[i].v);
         check($sformatf("v%0d if_pc", i),       bus.if_pc,         vecs[i].ipc);
         check($sformatf("v%0d if_sel", i),      32'(bus.if_sel),   vecs[i].isel);
         check($sformatf("v%0d imem_pc", i),     bus.imem_pc,       vecs[i].mpc);
         check($sformatf("v%0d imem_sel", i),    32'(bus.imem_sel), vecs[i].msel);
         check($sformatf("v%0d busy", i),        32'(busy),         vecs[i].busy);
         check($sformatf("v%0d done", i),        32'(done),         vecs[i].done);
         check($sformatf("v%0d instr_count", i), 32'(instr_count),  vecs[i].cnt);
         if (vecs[i].v != 0)
            check($sformatf("v%0d if_instr", i), bus.if_instr, rom_word(vecs[i].isel, vecs[i].ipc));
         else if (i == 0)
            check("v0 if_instr", bus.if_instr, 32'h0);
      end

      @(negedge clk);
      start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; bus.if_ready = 1'b1;
      rom0[3] = 32'hA000_0003;
      rom1[2] = 32'hB000_0002;

      // ROM1 fully populated: run must end on the depth bound, not chain further.
      run_to_done(1'b1, acc, lpc, dn, flips, fin);
      $display("bound run: accepted=%0d last_pc=%h dones=%0d flips=%0d finished=%0d cnt=%0d",
               acc, lpc, dn, flips, fin, instr_count);
      check("bound finished", 32'(fin), 32'd1);
      check("bound accepted", 32'(acc), 32'd77);
      check("bound last_pc", lpc, 32'h130);
      check("bound done pulses", 32'(dn), 32'd1);
      check("bound sel stays 1", 32'(flips), 32'd0);
      check("bound instr_count", 32'(instr_count), 32'd77);

      // Reset in the middle of a ROM0 run.
      @(negedge clk);
      start = 1'b1; start_sel = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      reached = 0;
      for (int c = 0; c < 200; c++) begin
         if (bus.imem_pc == 32'h40) begin
            reached = 1;
            break;
         end
         @(posedge clk); #1;
      end
      check("reset reached pc 0x40", 32'(reached), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      $display("reset mid-run: busy=%0d valid=%0d imem_pc=%h sel=%0d done=%0d cnt=%0d",
               busy, bus.if_valid, bus.imem_pc, bus.imem_sel, done, instr_count);
      check("reset busy", 32'(busy), 32'd0);
      check("reset if_valid", 32'(bus.if_valid), 32'd0);
      check("reset imem_pc", bus.imem_pc, 32'h0);
      check("reset imem_sel", 32'(bus.imem_sel), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset instr_count", 32'(instr_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (done || busy) dn++;
      end
      check("post-reset idle quiet", 32'(dn), 32'd0);

      run_to_done(1'b1, acc, lpc, dn, flips, fin);
      $display("rom1-only run: accepted=%0d last_pc=%h dones=%0d flips=%0d finished=%0d",
               acc, lpc, dn, flips, fin);
      check("rom1 run finished", 32'(fin), 32'd1);
      check("rom1 run accepted", 32'(acc), 32'd77);
      check("rom1 run done pulses", 32'(dn), 32'd1);
      check("rom1 run sel stays 1", 32'(flips), 32'd0);

      // Long run held inside ROM0 by a redirect loop to drive the counter into saturation.
      @(negedge clk);
      start = 1'b1; start_sel = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      reached = 0; sat_hits = 0; wraps = 0; dn = 0;
      for (int c = 0; c < 70000; c++) begin
         @(negedge clk);
         redirect_valid = (bus.imem_pc == 32'h100);
         redirect_pc    = 32'h0;
         @(posedge clk); #1;
         if (done) dn++;
         if (instr_count == 16'hFFFF) begin
            reached = 1;
            sat_hits++;
            if (sat_hits == 20) break;
         end else if (reached != 0) begin
            wraps++;
         end
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      $display("saturation: reached=%0d hits=%0d wraps=%0d dones=%0d cnt=%h",
               reached, sat_hits, wraps, dn, instr_count);
      check("sat reached", 32'(reached), 32'd1);
      check("sat held 20 cycles", 32'(sat_hits), 32'd20);
      check("sat no wrap", 32'(wraps), 32'd0);
      check("sat no done", 32'(dn), 32'd0);
      check("sat still busy", 32'(busy), 32'd1);

      rst_n = 1'b0;
      @(posedge clk); #1;
      check("final reset busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
